// File: rtl/vdp_vram_arbiter.sv
// VRAM port arbiter: display > sprite > CPU with CPU starvation override,
// one registered command per cycle and tag-routed read returns.
module vdp_vram_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_gnt,
    output logic              spr_rvalid,
    output logic [DATA_W-1:0] spr_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_SPR  = 2'd2,
        TAG_CPU  = 2'd3
    } tag_e;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    tag_e              tag_q [RD_LAT];
    tag_e              tag_d [RD_LAT];
    tag_e              tag_in_s;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic              spr_rvalid_q, spr_rvalid_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [DATA_W-1:0] disp_hold_q, disp_hold_d;
    logic [DATA_W-1:0] spr_hold_q, spr_hold_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
    logic              starved_s;

    assign starved_s = (starve_cnt_q == CNT_W'(STARVE_MAX));

    // Fixed-priority grant; a starved CPU jumps the sprite but never the display.
    always_comb begin
        disp_gnt = 1'b0;
        spr_gnt  = 1'b0;
        cpu_gnt  = 1'b0;
        if (!rst_L) begin
            disp_gnt = 1'b0;
        end else if (disp_req) begin
            disp_gnt = 1'b1;
        end else if (cpu_req && starved_s) begin
            cpu_gnt = 1'b1;
        end else if (spr_req) begin
            spr_gnt = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end else begin
            cpu_gnt = 1'b0;
        end
    end

    // Next command, starvation count, tag pipeline and read-return state.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        tag_in_s    = TAG_NONE;
        if (disp_gnt) begin
            mem_addr_d = disp_addr;
            mem_re_d   = 1'b1;
            tag_in_s   = TAG_DISP;
        end else if (spr_gnt) begin
            mem_addr_d = spr_addr;
            mem_re_d   = 1'b1;
            tag_in_s   = TAG_SPR;
        end else if (cpu_gnt) begin
            mem_addr_d = cpu_addr;
            mem_re_d   = ~cpu_we;
            mem_we_d   = cpu_we;
            tag_in_s   = cpu_we ? TAG_NONE : TAG_CPU;
            if (cpu_we) begin
                mem_wdata_d = cpu_wdata;
            end else begin
                mem_wdata_d = mem_wdata_q;
            end
        end else begin
            mem_addr_d = mem_addr_q;
        end

        if (cpu_req && !cpu_gnt) begin
            starve_cnt_d = starved_s ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = {CNT_W{1'b0}};
        end

        tag_d[0] = tag_in_s;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        disp_rvalid_d = 1'b0;
        spr_rvalid_d  = 1'b0;
        cpu_rvalid_d  = 1'b0;
        case (tag_q[RD_LAT-1])
            TAG_DISP: disp_rvalid_d = 1'b1;
            TAG_SPR:  spr_rvalid_d  = 1'b1;
            TAG_CPU:  cpu_rvalid_d  = 1'b1;
            default:  disp_rvalid_d = 1'b0;
        endcase

        // Read data is live during its rvalid cycle and latched for holding afterwards.
        disp_hold_d = disp_rvalid_q ? mem_rdata : disp_hold_q;
        spr_hold_d  = spr_rvalid_q  ? mem_rdata : spr_hold_q;
        cpu_hold_d  = cpu_rvalid_q  ? mem_rdata : cpu_hold_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            mem_addr_q    <= {ADDR_W{1'b0}};
            mem_wdata_q   <= {DATA_W{1'b0}};
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            starve_cnt_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
            disp_rvalid_q <= 1'b0;
            spr_rvalid_q  <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            disp_hold_q   <= {DATA_W{1'b0}};
            spr_hold_q    <= {DATA_W{1'b0}};
            cpu_hold_q    <= {DATA_W{1'b0}};
        end else begin
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_re_q      <= mem_re_d;
            mem_we_q      <= mem_we_d;
            starve_cnt_q  <= starve_cnt_d;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
            disp_rvalid_q <= disp_rvalid_d;
            spr_rvalid_q  <= spr_rvalid_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            disp_hold_q   <= disp_hold_d;
            spr_hold_q    <= spr_hold_d;
            cpu_hold_q    <= cpu_hold_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign disp_rvalid = disp_rvalid_q;
    assign spr_rvalid  = spr_rvalid_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign disp_rdata  = disp_rvalid_q ? mem_rdata : disp_hold_q;
    assign spr_rdata   = spr_rvalid_q  ? mem_rdata : spr_hold_q;
    assign cpu_rdata   = cpu_rvalid_q  ? mem_rdata : cpu_hold_q;

endmodule

// File: doc/vdp_vram_arbiter.md
Name: vdp_vram_arbiter

Overview:
- Shares one VRAM access port among three requesters: display fetch (vdp_disp_interface path), sprite scan, and CPU data port.
- Fixed priority: display > sprite > CPU, with a starvation override that promotes the CPU above sprite.
- Issues at most one registered memory command per cycle and routes read data back to the issuing requester using an in-flight tag pipeline.
- Sits between the requesters and the VRAM mem instance's port.

Parameters:
- ADDR_W, 14, VRAM address width
- DATA_W, 8, VRAM data width
- RD_LAT, 1, cycles from registered command to valid mem_rdata (1 or 2)
- STARVE_MAX, 4, consecutive denied CPU cycles before CPU beats sprite

Ports:
- clk  in  1  system clock
- rst_L  in  1  asynchronous active-low reset
- disp_req  in  1  display read request
- disp_addr  in  ADDR_W  display read address
- disp_gnt  out  1  display request accepted this cycle
- disp_rvalid  out  1  disp_rdata valid
- disp_rdata  out  DATA_W  display read data
- spr_req, spr_addr, spr_gnt, spr_rvalid, spr_rdata  (same shapes as display)  sprite scan read channel
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU request accepted (write completes on grant)
- cpu_rvalid  out  1  cpu_rdata valid (reads only)
- cpu_rdata  out  DATA_W  CPU read data
- mem_addr  out  ADDR_W  registered VRAM address
- mem_re  out  1  registered read strobe
- mem_we  out  1  registered write strobe
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  VRAM read data, valid RD_LAT cycles after mem_re

Behaviour:
- Reset (async, rst_L low): all outputs 0, starve counter 0, tag pipeline cleared.
  - No rvalid is ever produced for a command issued before reset.
- Grant logic (combinational):
  - Exactly one *_gnt may be high per cycle.
  - Winner = disp if disp_req; else CPU if cpu_req and starve_cnt == STARVE_MAX; else spr if spr_req; else CPU if cpu_req; else none.
- Requester handshake:
  - Hold req/addr/we/wdata stable until gnt is sampled high at a clock edge.
  - A requester may present a new request in the very next cycle (back-to-back, full throughput).
  - Dropping req before gnt is legal; the request is then lost with no side effects.
- Command stage: on each posedge, the winner's addr/wdata are registered onto mem_*.
  - mem_re = 1 for a read grant; mem_we = 1 for a CPU write grant.
  - With no winner, mem_re = mem_we = 0 and mem_addr/mem_wdata hold their previous values.
- Read return:
  - A tag (DISP/SPR/CPU/NONE) enters an RD_LAT-deep shift register together with the command.
  - When the tag exits, the matching *_rvalid pulses for 1 cycle with *_rdata = mem_rdata; the other channels' rdata hold.
  - Latency from gnt cycle to rvalid cycle = 1 + RD_LAT (2 at default).
  - CPU writes push tag NONE, so no rvalid.
- Ordering: commands execute in grant order. A CPU read granted after a CPU write to the same address returns the new data.
- Starvation counter (saturating at STARVE_MAX):
  - Increments each cycle cpu_req = 1 and cpu_gnt = 0.
  - Clears on cpu_gnt or when cpu_req = 0.
  - The override never preempts display: display can starve the CPU indefinitely (display is realtime).
- Simultaneous requests: all three high → disp wins; spr and CPU hold.
- Address wrap: none internal; addresses pass through unmodified.

Test Plan:
- Reset mid-stream: spr read of 0x0010 granted, rst_L pulsed low next cycle → no spr_rvalid, all outputs 0, mem_re = 0.
- Single read: VRAM[0x1234] = 0xA5, disp_req/addr = 0x1234 → disp_gnt same cycle, mem_re/mem_addr = 0x1234 at +1, disp_rvalid with 0xA5 at +2.
- Back-to-back: disp reads 0x0000..0x0007 on consecutive cycles → 8 grants, 8 rvalids in order, no gaps, data = VRAM contents.
- Priority: disp, spr, and cpu all request at once → disp_gnt only. Drop disp → spr_gnt. Drop spr → cpu_gnt.
- Starvation: spr_req held continuously, cpu_req write 0x3FFF ← 0x5A → cpu_gnt on the 5th cycle (STARVE_MAX = 4 denials), then spr resumes; a later CPU read of 0x3FFF returns 0x5A.
- RD_LAT = 2 build: interleaved disp and cpu reads → each rvalid arrives 3 cycles after its gnt on the correct channel, with no cross-routing.
